// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES widths, round counts and the round-sequencer FSM encoding.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 128;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY0  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block, round-key and round-datapath signals of the AES round sequencer.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;

    logic                 key_req;
    logic [3:0]           key_round;
    logic                 key_valid;
    logic [AES_KEY_W-1:0] key_data;

    logic [AES_BLK_W-1:0] dp_state;
    logic [AES_BLK_W-1:0] dp_mix_out;
    logic [AES_BLK_W-1:0] dp_nomix_out;

    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;

    logic                 busy;

    modport master (
        input  in_valid, in_data, key_valid, key_data, dp_mix_out, dp_nomix_out, out_ready,
        output in_ready, key_req, key_round, dp_state, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, key_valid, key_data, dp_mix_out, dp_nomix_out, out_ready,
        input  in_ready, key_req, key_round, dp_state, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES sequencer: AddRoundKey and key fetch around an external round datapath; AES_ABORT_EN adds an abort input.
// Ciphertext NR+2 cycles after accept when keys are ready; stalls on key_valid and holds DONE until out_ready.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef AES_ABORT_EN
    input  logic             abort,
`endif
    aes_round_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_KEY0  = KEY0;
    localparam logic [1:0] ST_ROUND = ROUND;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [3:0] NR_L = 4'(NR);

    logic [1:0]           fsm_q, fsm_d;
    logic [AES_BLK_W-1:0] state_q, state_d;
    logic [3:0]           rnd_q, rnd_d;
    logic [KEY_W-1:0]     rkey;
    logic                 abort_act;

    assign rkey = bus.key_data;

`ifdef AES_ABORT_EN
    assign abort_act = abort && (fsm_q != ST_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.in_data;
                    rnd_d   = 4'd0;
                    fsm_d   = ST_KEY0;
                end
            end
            ST_KEY0: begin
                if (bus.key_valid) begin
                    state_d = state_q ^ rkey;
                    rnd_d   = 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (bus.key_valid) begin
                    // Last round skips mixcolumn; rnd_q stays at NR so it never wraps.
                    if (rnd_q == NR_L) begin
                        state_d = bus.dp_nomix_out ^ rkey;
                        fsm_d   = ST_DONE;
                    end else begin
                        state_d = bus.dp_mix_out ^ rkey;
                        rnd_d   = rnd_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    rnd_d = 4'd0;
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
        if (abort_act) begin
            fsm_d   = ST_IDLE;
            state_d = '0;
            rnd_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rnd_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // in_ready is masked while reset is held so every control output reads 0 in reset.
    assign bus.in_ready  = rst_n && (fsm_q == ST_IDLE);
    assign bus.busy      = (fsm_q != ST_IDLE);
    assign bus.key_req   = (fsm_q == ST_KEY0) || (fsm_q == ST_ROUND);
    assign bus.key_round = rnd_q;
    assign bus.out_valid = (fsm_q == ST_DONE);
    assign bus.out_data  = state_q;
    assign bus.dp_state  = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: mock and real AES datapaths, keyed table vectors, corner sequences and random blocks.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef AES_ABORT_EN
    logic abort = 1'b0;
`endif

    aes_round_ctrl_if bus();

    aes_round_ctrl #(.NR(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] rk [0:15];
    int dp_mode = 0;
    int key_delay = 0;
    int kcnt = 0;

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq = a;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = b[4*((c+r)%4)+r];
        return o;
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] dp_mix(input logic [127:0] s, input int mode);
        case (mode)
            0:       return s;
            1:       return mixcols(sub_shift(s));
            default: return {s[119:0], s[127:120]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        endcase
    endfunction

    function automatic logic [127:0] dp_nomix(input logic [127:0] s, input int mode);
        case (mode)
            0:       return ~s;
            1:       return sub_shift(s);
            default: return {s[7:0], s[127:8]} ^ 128'hdeadbeef_01234567_89abcdef_55aa33cc;
        endcase
    endfunction

    // Whole-block model: initial AddRoundKey, NR-1 full rounds, final round without mixcolumn.
    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int mode);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r < NR; r++) s = dp_mix(s, mode) ^ rk[r];
        return dp_nomix(s, mode) ^ rk[NR];
    endfunction

    task automatic load_fips_keys(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_mock_keys();
        for (int r = 0; r < 16; r++) rk[r] = {16{8'(r)}};
    endtask

    // ---------------- Environment models ----------------
    always_comb begin
        bus.key_data     = rk[bus.key_round];
        bus.dp_mix_out   = dp_mix(bus.dp_state, dp_mode);
        bus.dp_nomix_out = dp_nomix(bus.dp_state, dp_mode);
    end

    assign bus.key_valid = (key_delay == 0) ? 1'b1 : (bus.key_req && kcnt == key_delay);

    always @(posedge clk) begin
        if (bus.key_req && !bus.key_valid) kcnt <= kcnt + 1;
        else kcnt <= 0;
    end

    // A request left waiting must be presented unchanged on the following cycle.
    logic       prev_wait = 1'b0;
    logic [3:0] prev_round = 4'd0;
    always @(negedge clk) begin
        if (prev_wait && rst_n) begin
            checks++;
            if (!(bus.key_req && bus.key_round == prev_round)) begin
                errors++;
                $display("FAIL key_hold got req=%0b round=%0d want req=1 round=%0d", bus.key_req, bus.key_round, prev_round);
            end
        end
        prev_wait  <= bus.key_req && !bus.key_valid;
        prev_round <= bus.key_round;
    end

    // ---------------- Check helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic accept(input string name, input logic [127:0] pt);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept"}, 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Entered on the first negedge after the accepting edge.
    task automatic finish_block(input string name, input logic [127:0] exp, input int exp_lat, input int hold);
        int lat = 1;
        while (!bus.out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 128'(lat), 128'(exp_lat));
        check({name, "_ct"}, bus.out_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_vr"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b10));
            check({name, "_hold_dat"}, bus.out_data, exp);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_ack"}, 128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b010));
        check({name, "_keep"}, bus.out_data, exp);
    endtask

    task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] exp,
                             input int exp_lat, input int hold);
        accept(name, pt);
        finish_block(name, exp, exp_lat, hold);
    endtask

    typedef struct {
        string        name;
        logic [127:0] pt;
        int           mode;
        int           delay;
        int           hold;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        load_mock_keys();

        tbl[0] = '{"mock_zero", 128'h0, 0, 0, 0, {16{8'hF4}}, NR + 2};
        tbl[1] = '{"mock_ones", {128{1'b1}}, 0, 0, 2, {16{8'h0B}}, NR + 2};
        tbl[2] = '{"fips197", 128'h00112233445566778899aabbccddeeff, 1, 0, 1,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, NR + 2};
        tbl[3] = '{"key_wait3", 128'h0, 0, 3, 5, {16{8'hF4}}, 45};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ctrl", 128'({bus.in_ready, bus.busy, bus.key_req, bus.out_valid}), 128'(4'b0000));
        check("rst_round", 128'(bus.key_round), 128'd0);
        check("rst_state", bus.dp_state, 128'h0);
        check("rst_out", bus.out_data, 128'h0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 128'({bus.in_ready, bus.busy}), 128'(2'b10));

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            dp_mode   = tbl[i].mode;
            key_delay = tbl[i].delay;
            if (tbl[i].mode == 1) load_fips_keys(128'h000102030405060708090a0b0c0d0e0f);
            else load_mock_keys();
            run_block(tbl[i].name, tbl[i].pt, tbl[i].exp, tbl[i].lat, tbl[i].hold);
        end

        // Back-to-back: second block waits for the cycle after the output handshake
        dp_mode = 0;
        key_delay = 0;
        load_mock_keys();
        accept("b2b_first", 128'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = {128{1'b1}};
        finish_block("b2b_first", {16{8'hF4}}, NR + 2, 5);
        @(negedge clk);
        check("b2b_second_taken", 128'(bus.busy), 128'd1);
        bus.in_valid = 1'b0;
        finish_block("b2b_second", {16{8'h0B}}, NR + 2, 0);

        // Synchronous reset in the middle of round 5
        accept("midrst", 128'h0123456789abcdef0123456789abcdef);
        n = 0;
        while (bus.key_round != 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach5", 128'(bus.key_round), 128'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ctrl", 128'({bus.in_ready, bus.busy, bus.key_req, bus.out_valid}), 128'(4'b1000));
        check("midrst_state", bus.dp_state, 128'h0);
        run_block("after_rst", 128'h0, {16{8'hF4}}, NR + 2, 0);

`ifdef AES_ABORT_EN
        // Abort in round 3 while key_valid is also high
        accept("abort_r3", 128'h0);
        n = 0;
        while (bus.key_round != 4'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach3", 128'({bus.key_round, bus.key_valid}), 128'({4'd3, 1'b1}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctrl", 128'({bus.in_ready, bus.busy, bus.key_req, bus.out_valid}), 128'(4'b1000));
        check("abort_state", bus.dp_state, 128'h0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_out", 128'(seen), 128'd0);
        // Abort wins over out_ready in DONE and clears the ciphertext
        accept("abort_done", 128'h0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_done_out", bus.out_data, 128'h0);
        check("abort_done_ctrl", 128'({bus.out_valid, bus.busy}), 128'(2'b00));
        // Abort in IDLE is ignored
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_idle_taken", 128'(bus.busy), 128'd1);
        finish_block("abort_idle", {16{8'hF4}}, NR + 2, 0);
`endif

        // Random blocks against the whole-block model
        for (int b = 0; b < 20; b++) begin
            logic [127:0] pt;
            dp_mode   = $urandom_range(0, 2);
            key_delay = $urandom_range(0, 3);
            pt = {$urandom, $urandom, $urandom, $urandom};
            for (int r = 0; r <= NR; r++) rk[r] = {$urandom, $urandom, $urandom, $urandom};
            run_block($sformatf("rand%0d", b), pt, ref_enc(pt, dp_mode),
                      1 + (NR + 1) * (key_delay + 1), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
